// File: rtl/types.sv
// Shared types for the load/store unit slice.
// Contents:
//   regaddr_t   - architectural register index
//   mem_op_e    - memory operation carried in EX/MEM
//   mem_size_e  - access width
//   lsu_state_e - load/store unit FSM state
//   helper functions for alignment checks, byte enables and store lanes
package types;

  typedef logic [4:0] regaddr_t;

  typedef enum logic [1:0] {
    MEM_OP_NONE  = 2'd0,
    MEM_OP_LOAD  = 2'd1,
    MEM_OP_STORE = 2'd2
  } mem_op_e;

  typedef enum logic [1:0] {
    MEM_SIZE_BYTE = 2'd0,
    MEM_SIZE_HALF = 2'd1,
    MEM_SIZE_WORD = 2'd2
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } lsu_state_e;

  // A half must sit on an even address, a word on a multiple of four.
  function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] byte_off);
    logic bad;
    case (size)
      MEM_SIZE_BYTE: bad = 1'b0;
      MEM_SIZE_HALF: bad = byte_off[0];
      MEM_SIZE_WORD: bad = (byte_off != 2'b00);
      default:       bad = (byte_off != 2'b00);
    endcase
    return bad;
  endfunction

  // Lane mask for the addressed bytes within the word.
  function automatic logic [3:0] byte_enables(input mem_size_e size, input logic [1:0] byte_off);
    logic [3:0] be;
    case (size)
      MEM_SIZE_BYTE: be = 4'b0001 << byte_off;
      MEM_SIZE_HALF: be = 4'b0011 << byte_off;
      MEM_SIZE_WORD: be = 4'b1111;
      default:       be = 4'b1111;
    endcase
    return be;
  endfunction

  // Replicating the low-order data across lanes lets the byte enables pick
  // the right lane without a barrel shifter.
  function automatic logic [31:0] store_lanes(input mem_size_e size, input logic [31:0] data);
    logic [31:0] lanes;
    case (size)
      MEM_SIZE_BYTE: lanes = {4{data[7:0]}};
      MEM_SIZE_HALF: lanes = {2{data[15:0]}};
      MEM_SIZE_WORD: lanes = data;
      default:       lanes = data;
    endcase
    return lanes;
  endfunction

endpackage

// File: rtl/load_align.sv
// Load data aligner: picks the addressed byte or half out of a bus word and
// zero- or sign-extends it to 32 bits. Purely combinational.
// Ports:
//   rdata     in  32  word read from the data bus
//   byte_off  in  2   low address bits of the access
//   size      in      access width
//   is_signed in  1   sign-extend sub-word results
//   data      out 32  aligned, extended result
module load_align
  import types::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  byte_off,
  input  mem_size_e   size,
  input  logic        is_signed,
  output logic [31:0] data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane selection followed by extension by access width.
  always_comb begin
    byte_s = 8'd0;
    half_s = 16'd0;
    data   = 32'd0;
    case (byte_off)
      2'd0:    byte_s = rdata[7:0];
      2'd1:    byte_s = rdata[15:8];
      2'd2:    byte_s = rdata[23:16];
      2'd3:    byte_s = rdata[31:24];
      default: byte_s = rdata[7:0];
    endcase
    if (byte_off[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (size)
      MEM_SIZE_BYTE: data = {{24{is_signed & byte_s[7]}}, byte_s};
      MEM_SIZE_HALF: data = {{16{is_signed & half_s[15]}}, half_s};
      MEM_SIZE_WORD: data = rdata;
      default:       data = rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage load/store unit. Accepts a memory op from EX/MEM, runs one
// req/ack transaction on the data bus, aligns/extends load data and hands it
// with its destination register to MEM/WB. Stalls the pipeline while a
// transaction is outstanding; faults on misalignment and on bus timeout.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   mem_op, mem_size, mem_signed   operation from EX/MEM
//   addr, store_data, rd_addr      byte address, store source, load dest
//   dbus_req/we/addr/be/wdata      data bus request side (registered)
//   dbus_ack, dbus_rdata           data bus response side
//   mem_stall                      pipeline freeze (combinational)
//   load_valid/data/rd_addr        load result to MEM/WB
//   misaligned                     misaligned-access pulse (combinational)
//   bus_fault                      ack-timeout pulse
module load_store_unit
  import types::*;
#(
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  mem_op_e     mem_op,
  input  mem_size_e   mem_size,
  input  logic        mem_signed,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  regaddr_t    rd_addr,
  output logic        dbus_req,
  output logic        dbus_we,
  output logic [31:0] dbus_addr,
  output logic [3:0]  dbus_be,
  output logic [31:0] dbus_wdata,
  input  logic        dbus_ack,
  input  logic [31:0] dbus_rdata,
  output logic        mem_stall,
  output logic        load_valid,
  output logic [31:0] load_data,
  output regaddr_t    load_rd_addr,
  output logic        misaligned,
  output logic        bus_fault
);

  localparam logic [7:0] TIMEOUT_C = 8'(ACK_TIMEOUT);

  lsu_state_e  state_r;
  logic [7:0]  timer_r;
  logic [7:0]  timer_next_s;
  logic [1:0]  byte_off_r;
  mem_size_e   size_r;
  logic        signed_r;
  logic        is_load_r;
  regaddr_t    rd_r;
  logic        accept_s;
  logic [31:0] aligned_s;

  // Align the bus word using the fields latched when the op was accepted.
  load_align u_load_align (
    .rdata     (dbus_rdata),
    .byte_off  (byte_off_r),
    .size      (size_r),
    .is_signed (signed_r),
    .data      (aligned_s)
  );

  // Op acceptance, misalignment detection and pipeline stall.
  always_comb begin
    accept_s     = 1'b0;
    misaligned   = 1'b0;
    timer_next_s = timer_r + 8'd1;
    if ((state_r == IDLE) && (mem_op != MEM_OP_NONE)) begin
      if (is_misaligned(mem_size, addr[1:0])) begin
        misaligned = 1'b1;
      end else begin
        accept_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
    end
    // Stall starts combinationally in the accept cycle so EX/MEM holds the op.
    mem_stall = accept_s || (state_r == BUSY);
  end

  // Transaction FSM with registered bus and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      timer_r      <= 8'd0;
      byte_off_r   <= 2'd0;
      size_r       <= MEM_SIZE_BYTE;
      signed_r     <= 1'b0;
      is_load_r    <= 1'b0;
      rd_r         <= 5'd0;
      dbus_req     <= 1'b0;
      dbus_we      <= 1'b0;
      dbus_addr    <= 32'd0;
      dbus_be      <= 4'd0;
      dbus_wdata   <= 32'd0;
      load_valid   <= 1'b0;
      load_data    <= 32'd0;
      load_rd_addr <= 5'd0;
      bus_fault    <= 1'b0;
    end else begin
      bus_fault <= 1'b0;
      case (state_r)
        IDLE: begin
          load_valid <= 1'b0;
          timer_r    <= 8'd0;
          if (accept_s) begin
            dbus_req   <= 1'b1;
            dbus_we    <= (mem_op == MEM_OP_STORE);
            dbus_addr  <= {addr[31:2], 2'b00};
            dbus_be    <= byte_enables(mem_size, addr[1:0]);
            dbus_wdata <= store_lanes(mem_size, store_data);
            byte_off_r <= addr[1:0];
            size_r     <= mem_size;
            signed_r   <= mem_signed;
            is_load_r  <= (mem_op == MEM_OP_LOAD);
            rd_r       <= rd_addr;
            state_r    <= BUSY;
          end
        end
        BUSY: begin
          // Ack takes priority over a timeout expiring in the same cycle.
          if (dbus_ack) begin
            dbus_req <= 1'b0;
            if (is_load_r) begin
              load_valid   <= 1'b1;
              load_data    <= aligned_s;
              load_rd_addr <= rd_r;
            end
            state_r <= DONE;
          end else if (timer_next_s == TIMEOUT_C) begin
            dbus_req  <= 1'b0;
            bus_fault <= 1'b1;
            state_r   <= DONE;
          end else begin
            timer_r <= timer_next_s;
          end
        end
        DONE: begin
          // mem_op still shows the retiring instruction here, so it is ignored.
          load_valid <= 1'b0;
          state_r    <= IDLE;
        end
        default: begin
          dbus_req   <= 1'b0;
          load_valid <= 1'b0;
          state_r    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed self-checking bench for load_store_unit (ACK_TIMEOUT=4) plus a
// few standalone vectors for load_align.
module tb_load_store_unit;
  import types::*;

  logic        clk = 1'b0;
  logic        rst_n;
  mem_op_e     mem_op;
  mem_size_e   mem_size;
  logic        mem_signed;
  logic [31:0] addr;
  logic [31:0] store_data;
  regaddr_t    rd_addr;
  logic        dbus_req;
  logic        dbus_we;
  logic [31:0] dbus_addr;
  logic [3:0]  dbus_be;
  logic [31:0] dbus_wdata;
  logic        dbus_ack;
  logic [31:0] dbus_rdata;
  logic        mem_stall;
  logic        load_valid;
  logic [31:0] load_data;
  regaddr_t    load_rd_addr;
  logic        misaligned;
  logic        bus_fault;

  logic [31:0] la_rdata;
  logic [1:0]  la_off;
  mem_size_e   la_size;
  logic        la_signed;
  logic [31:0] la_data;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  load_store_unit #(.ACK_TIMEOUT(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mem_op       (mem_op),
    .mem_size     (mem_size),
    .mem_signed   (mem_signed),
    .addr         (addr),
    .store_data   (store_data),
    .rd_addr      (rd_addr),
    .dbus_req     (dbus_req),
    .dbus_we      (dbus_we),
    .dbus_addr    (dbus_addr),
    .dbus_be      (dbus_be),
    .dbus_wdata   (dbus_wdata),
    .dbus_ack     (dbus_ack),
    .dbus_rdata   (dbus_rdata),
    .mem_stall    (mem_stall),
    .load_valid   (load_valid),
    .load_data    (load_data),
    .load_rd_addr (load_rd_addr),
    .misaligned   (misaligned),
    .bus_fault    (bus_fault)
  );

  load_align u_la (
    .rdata     (la_rdata),
    .byte_off  (la_off),
    .size      (la_size),
    .is_signed (la_signed),
    .data      (la_data)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One complete op with ack in the first BUSY cycle.
  task automatic run_op(input string tag, input mem_op_e op, input mem_size_e sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] sd,
                        input logic [4:0] rd, input logic [31:0] rdata,
                        input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                        input logic exp_we, input logic exp_lv, input logic [31:0] exp_ld);
    logic [31:0] exp_addr;
    exp_addr = {a[31:2], 2'b00};
    step();
    mem_op = op; mem_size = sz; mem_signed = sg; addr = a; store_data = sd; rd_addr = rd;
    #1;
    chk({tag, ".c0_stall"}, 32'(mem_stall), 32'd1);
    chk({tag, ".c0_req"}, 32'(dbus_req), 32'd0);
    step();
    dbus_ack = 1'b1; dbus_rdata = rdata;
    #1;
    chk({tag, ".c1_req"}, 32'(dbus_req), 32'd1);
    chk({tag, ".c1_stall"}, 32'(mem_stall), 32'd1);
    chk({tag, ".c1_we"}, 32'(dbus_we), 32'(exp_we));
    chk({tag, ".c1_addr"}, dbus_addr, exp_addr);
    chk({tag, ".c1_be"}, 32'(dbus_be), 32'(exp_be));
    if (exp_we) chk({tag, ".c1_wdata"}, dbus_wdata, exp_wdata);
    step();
    dbus_ack = 1'b0; dbus_rdata = 32'd0; mem_op = MEM_OP_NONE;
    #1;
    chk({tag, ".c2_stall"}, 32'(mem_stall), 32'd0);
    chk({tag, ".c2_req"}, 32'(dbus_req), 32'd0);
    chk({tag, ".c2_lv"}, 32'(load_valid), 32'(exp_lv));
    chk({tag, ".c2_ld"}, load_data, exp_ld);
    chk({tag, ".c2_fault"}, 32'(bus_fault), 32'd0);
    if (exp_lv) chk({tag, ".c2_rd"}, 32'(load_rd_addr), 32'(rd));
    step();
    #1;
    chk({tag, ".c3_lv"}, 32'(load_valid), 32'd0);
    chk({tag, ".c3_stall"}, 32'(mem_stall), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; mem_op = MEM_OP_NONE; mem_size = MEM_SIZE_WORD; mem_signed = 1'b0;
    addr = 32'd0; store_data = 32'd0; rd_addr = 5'd0; dbus_ack = 1'b0; dbus_rdata = 32'd0;
    la_rdata = 32'd0; la_off = 2'd0; la_size = MEM_SIZE_WORD; la_signed = 1'b0;
    #12;
    chk("rst.req", 32'(dbus_req), 32'd0);
    chk("rst.be", 32'(dbus_be), 32'd0);
    chk("rst.addr", dbus_addr, 32'd0);
    chk("rst.ld", load_data, 32'd0);
    chk("rst.rd", 32'(load_rd_addr), 32'd0);
    chk("rst.lv", 32'(load_valid), 32'd0);
    chk("rst.stall", 32'(mem_stall), 32'd0);
    rst_n = 1'b1;

    run_op("wload", MEM_OP_LOAD, MEM_SIZE_WORD, 1'b0, 32'h100, 32'd0, 5'd7, 32'hDEADBEEF,
           4'hF, 32'd0, 1'b0, 1'b1, 32'hDEADBEEF);
    run_op("sbyte", MEM_OP_LOAD, MEM_SIZE_BYTE, 1'b1, 32'h103, 32'd0, 5'd9, 32'h80112233,
           4'h8, 32'd0, 1'b0, 1'b1, 32'hFFFFFF80);
    run_op("ubyte", MEM_OP_LOAD, MEM_SIZE_BYTE, 1'b0, 32'h103, 32'd0, 5'd10, 32'h80112233,
           4'h8, 32'd0, 1'b0, 1'b1, 32'h00000080);
    run_op("hstore", MEM_OP_STORE, MEM_SIZE_HALF, 1'b0, 32'h202, 32'h1234ABCD, 5'd3, 32'd0,
           4'hC, 32'hABCDABCD, 1'b1, 1'b0, 32'h00000080);
    run_op("bstore", MEM_OP_STORE, MEM_SIZE_BYTE, 1'b0, 32'h205, 32'h000000A5, 5'd3, 32'd0,
           4'h2, 32'hA5A5A5A5, 1'b1, 1'b0, 32'h00000080);
    run_op("shalf", MEM_OP_LOAD, MEM_SIZE_HALF, 1'b1, 32'h102, 32'd0, 5'd11, 32'h80112233,
           4'hC, 32'd0, 1'b0, 1'b1, 32'hFFFF8011);

    // Misaligned word load: no request, no stall, single pulse.
    step();
    mem_op = MEM_OP_LOAD; mem_size = MEM_SIZE_WORD; addr = 32'h101; rd_addr = 5'd12;
    #1;
    chk("mis.pulse", 32'(misaligned), 32'd1);
    chk("mis.stall", 32'(mem_stall), 32'd0);
    step();
    mem_op = MEM_OP_NONE;
    #1;
    chk("mis.req", 32'(dbus_req), 32'd0);
    chk("mis.pulse_end", 32'(misaligned), 32'd0);
    chk("mis.lv", 32'(load_valid), 32'd0);

    // Stray ack while idle is ignored.
    dbus_ack = 1'b1;
    step();
    #1;
    chk("stray.req", 32'(dbus_req), 32'd0);
    chk("stray.lv", 32'(load_valid), 32'd0);
    dbus_ack = 1'b0;

    // Timeout with no ack: request held 4 cycles, then fault.
    step();
    mem_op = MEM_OP_LOAD; mem_size = MEM_SIZE_WORD; addr = 32'h300; rd_addr = 5'd4;
    #1;
    for (int i = 1; i <= 4; i++) begin
      step();
      #1;
      chk($sformatf("to.req%0d", i), 32'(dbus_req), 32'd1);
      chk($sformatf("to.stall%0d", i), 32'(mem_stall), 32'd1);
      chk($sformatf("to.fault%0d", i), 32'(bus_fault), 32'd0);
    end
    step();
    mem_op = MEM_OP_NONE;
    #1;
    chk("to.req_drop", 32'(dbus_req), 32'd0);
    chk("to.fault", 32'(bus_fault), 32'd1);
    chk("to.lv", 32'(load_valid), 32'd0);
    chk("to.stall", 32'(mem_stall), 32'd0);
    chk("to.ld_hold", load_data, 32'hFFFF8011);
    step();
    #1;
    chk("to.fault_end", 32'(bus_fault), 32'd0);

    // Reset asserted mid-BUSY drops the request immediately.
    step();
    mem_op = MEM_OP_LOAD; mem_size = MEM_SIZE_WORD; addr = 32'h400; rd_addr = 5'd6;
    #1;
    step();
    chk("rb.req_busy", 32'(dbus_req), 32'd1);
    mem_op = MEM_OP_NONE;
    rst_n = 1'b0;
    #1;
    chk("rb.req_drop", 32'(dbus_req), 32'd0);
    chk("rb.ld_clr", load_data, 32'd0);
    chk("rb.stall", 32'(mem_stall), 32'd0);
    #2;
    rst_n = 1'b1;
    run_op("post_rst", MEM_OP_LOAD, MEM_SIZE_WORD, 1'b0, 32'h404, 32'd0, 5'd6, 32'h0BADF00D,
           4'hF, 32'd0, 1'b0, 1'b1, 32'h0BADF00D);

    // Standalone aligner vectors.
    la_rdata = 32'h80112233;
    la_size = MEM_SIZE_HALF; la_off = 2'd2; la_signed = 1'b1; #1;
    chk("la.shalf_hi", la_data, 32'hFFFF8011);
    la_size = MEM_SIZE_HALF; la_off = 2'd0; la_signed = 1'b1; #1;
    chk("la.shalf_lo", la_data, 32'h00002233);
    la_size = MEM_SIZE_BYTE; la_off = 2'd1; la_signed = 1'b0; #1;
    chk("la.ubyte1", la_data, 32'h00000022);
    la_size = MEM_SIZE_BYTE; la_off = 2'd3; la_signed = 1'b0; #1;
    chk("la.ubyte3", la_data, 32'h00000080);
    la_size = MEM_SIZE_WORD; la_off = 2'd0; la_signed = 1'b1; #1;
    chk("la.word", la_data, 32'h80112233);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage load/store unit: the completing end of a load whose dependency the ID-stage load-hazard check stalls on. Takes the memory operation latched in EX/MEM, runs a req/ack transaction on the data bus, aligns and extends load data, and returns it with its destination register to MEM/WB. Holds the whole pipeline via `mem_stall` while a transaction is outstanding. Faults on misaligned accesses and on a bus that never acknowledges.

## Interface
- `ACK_TIMEOUT`, default 255: bus cycles to wait for `dbus_ack` before aborting; range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_op` in `mem_op_e`: `MEM_OP_NONE`, `MEM_OP_LOAD`, or `MEM_OP_STORE`; comes from EX/MEM.
- `mem_size` in `mem_size_e`: byte, half, or word.
- `mem_signed` in 1: sign-extend sub-word loads.
- `addr` in 32: effective byte address.
- `store_data` in 32: unaligned source data, carried in the low bits.
- `rd_addr` in `regaddr_t`: load destination register.
- `dbus_req` out 1: transaction request.
- `dbus_we` out 1: 1 = store.
- `dbus_addr` out 32: word-aligned address, `{addr[31:2],2'b00}`.
- `dbus_be` out 4: byte enables.
- `dbus_wdata` out 32: store data shifted to the correct lanes.
- `dbus_ack` in 1: transaction complete; `dbus_rdata` is valid in this cycle.
- `dbus_rdata` in 32: read word.
- `mem_stall` out 1: freeze PC, IF/ID, ID/EX, and EX/MEM.
- `load_valid` out 1: load result is valid for MEM/WB.
- `load_data` out 32: aligned, extended load result.
- `load_rd_addr` out `regaddr_t`: destination register for `load_data`.
- `misaligned` out 1: one-cycle fault pulse.
- `bus_fault` out 1: one-cycle timeout pulse.

## Operation
- FSM states: `IDLE`, `BUSY`, `DONE`.
- **IDLE, aligned operation** (`mem_op` ≠ NONE):
  - `mem_stall` = 1, combinational.
  - Register the bus fields; `dbus_req` ← 1.
  - Timer ← 0.
  - Next state `BUSY`.
- **IDLE, misaligned operation** (half with `addr[0]`=1, or word with `addr[1:0]` ≠ 0):
  - No bus request; `misaligned` = 1 for this cycle; `mem_stall` = 0.
  - Stay in `IDLE`.
- **BUSY:**
  - `mem_stall` = 1.
  - `dbus_addr`, `dbus_we`, `dbus_be`, and `dbus_wdata` are held constant.
  - On `dbus_ack`:
    - `dbus_req` ← 0.
    - For a load, capture the aligned and extended `dbus_rdata`.
    - Next state `DONE`.
  - Otherwise the timer increments. When it reaches `ACK_TIMEOUT`:
    - `dbus_req` ← 0; `bus_fault` is pulsed.
    - Next state `DONE`; `load_valid` stays 0.
- **DONE:**
  - `mem_stall` = 0, so the pipeline advances at the end of this cycle.
  - `load_valid` = 1 only if the operation was a load completed by ack.
  - Next state `IDLE`.
  - `mem_op` is ignored in `DONE`: it still shows the retiring instruction.
- **Byte enables:**
  - byte: `4'b0001 << addr[1:0]`.
  - half: `4'b0011 << addr[1:0]`.
  - word: `4'b1111`.
- **Store lanes:** byte data is replicated to all four lanes; half data is replicated to both halves.
- **Load:**
  - Select the byte or half at `addr[1:0]`.
  - Zero-extend, or sign-extend if `mem_signed`.
  - Word loads pass through unchanged.
- A stray `dbus_ack` in `IDLE` or `DONE` is ignored.

## Timing
- **Reset values:** state `IDLE`; all outputs 0, including `load_data`, `load_rd_addr`, and the `dbus_*` outputs.
- A reset assertion while in `BUSY` drops `dbus_req` immediately (asynchronous).
- **Minimum latency:**
  - op in cycle 0, `dbus_req` in cycle 1, ack in cycle 1, `DONE` / `load_valid` in cycle 2.
  - Each memory op costs 3 cycles, plus the bus wait.
- `mem_stall` is high in cycle 0 and in every `BUSY` cycle, and low in `DONE`.
- Back-to-back ops: a new op is accepted in the cycle after `DONE`.
- Ack in the same cycle the timer reaches `ACK_TIMEOUT`: the ack wins and there is no fault.
- `load_data` and `load_rd_addr` hold their value until the next completed load.

## Structure
- Package `types`:
  - add `mem_size_e`;
  - add the `lsu_state_e` enum;
  - reuse `regaddr_t` and `mem_op_e`.
- Sub-module `load_align`: combinational extraction and extension of `dbus_rdata` by `addr[1:0]`, size, and signedness. It is tested standalone.

## Test plan
- **Word load**, `addr`=0x100, ack in cycle 1, rdata 0xDEADBEEF:
  - `dbus_be`=0xF;
  - `load_valid` in cycle 2 with 0xDEADBEEF and the correct `load_rd_addr`;
  - stall for cycles 0–1.
- **Signed byte load**, `addr`=0x103, rdata 0x80112233:
  - `load_data`=0xFFFFFF80;
  - unsigned variant gives 0x00000080.
- **Half store**, `addr`=0x202, data 0x1234ABCD:
  - `dbus_we`=1, `dbus_be`=0xC, `dbus_wdata`=0xABCDABCD;
  - `load_valid` stays 0.
- **Word load at 0x101:** `misaligned` pulses once, no `dbus_req`, `mem_stall`=0.
- **`ACK_TIMEOUT`=4 with no ack:**
  - `dbus_req` held for 4 cycles, then drops;
  - `bus_fault` pulses; `load_valid`=0.
- **`rst_n` low mid-`BUSY`:** `dbus_req` drops immediately; after release the unit is in `IDLE` and a fresh load completes normally.
